// File: rtl/rps_match_ctrl.sv
// Best-of-N rock-paper-scissors match sequencer: arms rounds from a free-running LFSR,
// judges one player button per round, keeps scores and declares the match winner.
module rps_match_ctrl #(
    parameter int unsigned WIN_TARGET     = 3,
    parameter int unsigned SHOW_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       start,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    output logic [1:0] fpga_choice,
    output logic [1:0] result,
    output logic [2:0] score_player,
    output logic [2:0] score_fpga,
    output logic [3:0] round_cnt,
    output logic       match_done,
    output logic       match_winner
);
    localparam int unsigned TMAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    TARGET    = 3'(WIN_TARGET);

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_DRAW    = 2'b01;
    localparam logic [1:0] RES_PLAYER  = 2'b10;
    localparam logic [1:0] RES_FPGA    = 2'b11;
    localparam logic [1:0] MV_SCISSORS = 2'd0;
    localparam logic [1:0] MV_ROCK     = 2'd1;
    localparam logic [1:0] MV_PAPER    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_JUDGE,
        ST_SHOW,
        ST_DONE
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    lfsr;
    logic          lfsr_fb;
    logic          start_q, s1_q, s2_q, s3_q;
    logic          rise_start, rise_s1, rise_s2, rise_s3;
    logic [1:0]    move_q, move_d;
    logic          timed_out, timed_out_d;
    logic          player_wins;

    logic [1:0]    choice_d, result_d;
    logic [2:0]    sp_d, sf_d;
    logic [3:0]    rc_d;
    logic          done_d, winner_d;

    assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign rise_start = start & ~start_q;
    assign rise_s1    = s1 & ~s1_q;
    assign rise_s2    = s2 & ~s2_q;
    assign rise_s3    = s3 & ~s3_q;

    assign player_wins = (move_q == MV_ROCK     && fpga_choice == MV_SCISSORS) ||
                         (move_q == MV_PAPER    && fpga_choice == MV_ROCK)     ||
                         (move_q == MV_SCISSORS && fpga_choice == MV_PAPER);

    always_comb begin
        state_d     = state;
        timer_d     = timer;
        move_d      = move_q;
        timed_out_d = timed_out;
        choice_d    = fpga_choice;
        result_d    = result;
        sp_d        = score_player;
        sf_d        = score_fpga;
        rc_d        = round_cnt;
        done_d      = match_done;
        winner_d    = match_winner;

        case (state)
            ST_IDLE: begin
                result_d = RES_NONE;
                if (rise_start) state_d = ST_ARM;
            end
            ST_ARM: begin
                choice_d = 2'(lfsr % 8'd3);
                result_d = RES_NONE;
                timer_d  = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer + TW'(1);
                // A button edge on the last timeout cycle still counts as a real move.
                if (rise_s1 || rise_s2 || rise_s3) begin
                    move_d      = rise_s1 ? MV_SCISSORS : (rise_s2 ? MV_ROCK : MV_PAPER);
                    timed_out_d = 1'b0;
                    state_d     = ST_JUDGE;
                end else if (timer == TO_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                if (timed_out) begin
                    result_d = RES_FPGA;
                    sf_d     = score_fpga + 3'd1;
                end else if (move_q == fpga_choice) begin
                    result_d = RES_DRAW;
                end else if (player_wins) begin
                    result_d = RES_PLAYER;
                    sp_d     = score_player + 3'd1;
                end else begin
                    result_d = RES_FPGA;
                    sf_d     = score_fpga + 3'd1;
                end
                rc_d    = (round_cnt == 4'd15) ? round_cnt : round_cnt + 4'd1;
                timer_d = '0;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                timer_d = timer + TW'(1);
                if (timer == SHOW_LAST) begin
                    if (score_player == TARGET || score_fpga == TARGET) begin
                        done_d   = 1'b1;
                        winner_d = (score_player == TARGET);
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
            end
            ST_DONE: begin
                if (rise_start) begin
                    sp_d    = '0;
                    sf_d    = '0;
                    rc_d    = '0;
                    done_d  = 1'b0;
                    state_d = ST_ARM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= ST_IDLE;
            timer        <= '0;
            lfsr         <= LFSR_SEED;
            start_q      <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            move_q       <= '0;
            timed_out    <= 1'b0;
            fpga_choice  <= '0;
            result       <= '0;
            score_player <= '0;
            score_fpga   <= '0;
            round_cnt    <= '0;
            match_done   <= 1'b0;
            match_winner <= 1'b0;
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            lfsr         <= {lfsr[6:0], lfsr_fb};
            start_q      <= start;
            s1_q         <= s1;
            s2_q         <= s2;
            s3_q         <= s3;
            move_q       <= move_d;
            timed_out    <= timed_out_d;
            fpga_choice  <= choice_d;
            result       <= result_d;
            score_player <= sp_d;
            score_fpga   <= sf_d;
            round_cnt    <= rc_d;
            match_done   <= done_d;
            match_winner <= winner_d;
        end
    end

endmodule
